ts_event_timer: RTL and testbench

Programmable countdown event timer for the timescale diagnostics. A stimulus module loads a count through a valid/ready handshake. The timer decrements once every PRESCALE clocks and pulses `expire` when the count runs out, in one-shot or periodic mode. It sits directly beneath the diagnostic's top-level module as the timed design under test. Its `expire` and `count` outputs give the dumped waveform deterministic, timescale-sensitive transitions for coverage checking.

---
 rtl/ts_pkg.sv | 18 +
 rtl/ts_prescaler.sv | 33 +++
 rtl/ts_event_timer.sv | 100 ++++++++++
 tb/tb_ts_event_timer.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/ts_pkg.sv
// Shared types and constants for the countdown event timer.
`default_nettype none

package ts_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic MODE_ONESHOT  = 1'b0;
  localparam logic MODE_PERIODIC = 1'b1;

  localparam logic [7:0] EXPIRE_CNT_MAX = 8'd255;

endpackage

`default_nettype wire

// File: rtl/ts_prescaler.sv
// Free-running clock divider; tick marks the last clock of each PRESCALE window.
`default_nettype none

module ts_prescaler #(
  parameter int PRESCALE = 4
) (
  input  logic clock,
  input  logic reset_n,
  input  logic enable,
  input  logic clear,
  output logic tick
);

  localparam int PW = $clog2(PRESCALE);
  localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] cnt;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= (cnt == LAST) ? '0 : cnt + PW'(1);
    end
  end

  assign tick = enable && (cnt == LAST);

endmodule

`default_nettype wire

// File: rtl/ts_event_timer.sv
// Countdown event timer with valid/ready load, one-shot or periodic expiry,
// cancel and a saturating expiry counter.
`default_nettype none

module ts_event_timer
  import ts_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int PRESCALE = 4
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_value,
  input  logic             mode,
  input  logic             cancel,
  output logic             busy,
  output logic             expire,
  output logic [WIDTH-1:0] count,
  output logic [7:0]       expire_cnt
);

  state_t           state, next_state;
  logic [WIDTH-1:0] reload;
  logic             mode_r;
  logic             tick;
  logic             accept;
  logic             run_tick;
  logic             expire_hit;

  // Prescaler sits at zero while idle so every accepted load starts a full window.
  ts_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clock   (clock),
    .reset_n (reset_n),
    .enable  (state == RUN),
    .clear   (state == IDLE),
    .tick    (tick)
  );

  assign load_ready = (state == IDLE);
  assign busy       = (state == RUN);
  assign accept     = (state == IDLE) && load_valid;
  assign run_tick   = (state == RUN) && !cancel && tick;
  assign expire_hit = run_tick && (count == '0);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (load_valid) next_state = RUN;
      end
      RUN: begin
        if (cancel) begin
          next_state = IDLE;
        end else if (expire_hit && (mode_r == MODE_ONESHOT)) begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count      <= '0;
      reload     <= '0;
      mode_r     <= MODE_ONESHOT;
      expire     <= 1'b0;
      expire_cnt <= '0;
    end else begin
      expire <= expire_hit;
      if (accept) begin
        count  <= load_value;
        reload <= load_value;
        mode_r <= mode;
      end else if (run_tick) begin
        if (count == '0) begin
          if (mode_r == MODE_PERIODIC) count <= reload;
          if (expire_cnt != EXPIRE_CNT_MAX) expire_cnt <= expire_cnt + 8'd1;
        end else begin
          count <= count - WIDTH'(1);
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ts_event_timer.sv
// Directed, table-driven bench for ts_event_timer (WIDTH=8, PRESCALE=4).
`default_nettype none

module tb_ts_event_timer;

  localparam int PS = 4;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       load_valid = 1'b0;
  logic       load_ready;
  logic [7:0] load_value = 8'd0;
  logic       mode = 1'b0;
  logic       cancel = 1'b0;
  logic       busy;
  logic       expire;
  logic [7:0] count;
  logic [7:0] expire_cnt;

  int n_cmp  = 0;
  int n_fail = 0;
  int exp_ecnt = 0;

  typedef struct {
    int n;
    bit per;
    int nexp;
    int lat;
    int fcount;
  } vec_t;

  vec_t vecs[5];

  ts_event_timer #(.WIDTH(8), .PRESCALE(PS)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_value (load_value),
    .mode       (mode),
    .cancel     (cancel),
    .busy       (busy),
    .expire     (expire),
    .count      (count),
    .expire_cnt (expire_cnt)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic bump_ecnt();
    if (exp_ecnt < 255) exp_ecnt++;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_ready"}, 32'(load_ready), 1);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_expire"}, 32'(expire), 0);
    check({tag, "_count"}, 32'(count), 0);
    check({tag, "_ecnt"}, 32'(expire_cnt), 0);
  endtask

  // Load n, watch nexp expirations spaced lat clocks apart, cancel if periodic.
  task automatic run_load(input int n, input bit per, input int nexp, input int lat, input int fcount);
    check("ready_pre", 32'(load_ready), 1);
    load_valid = 1'b1;
    load_value = 8'(n);
    mode       = per;
    step();
    load_valid = 1'b0;
    check("load_busy", 32'(busy), 1);
    check("load_count", 32'(count), 32'(n));
    check("load_ready", 32'(load_ready), 0);
    for (int e = 0; e < nexp; e++) begin
      for (int k = 1; k <= lat; k++) begin
        step();
        if (k < lat) begin
          check("no_expire", 32'(expire), 0);
          check("countdown", 32'(count), 32'(n - k / PS));
        end else begin
          bump_ecnt();
          check("expire", 32'(expire), 1);
          check("expire_cnt", 32'(expire_cnt), 32'(exp_ecnt));
          check("busy_at_expire", 32'(busy), 32'(per));
          check("ready_at_expire", 32'(load_ready), 32'(!per));
          check("count_at_expire", 32'(count), 32'(fcount));
        end
      end
    end
    if (per) begin
      cancel = 1'b1;
      step();
      cancel = 1'b0;
      check("cancel_busy", 32'(busy), 0);
      check("cancel_expire", 32'(expire), 0);
      check("cancel_count", 32'(count), 32'(fcount));
    end else begin
      step();
      check("pulse_width", 32'(expire), 0);
      check("idle_ready", 32'(load_ready), 1);
    end
  endtask

  initial begin
    // n, periodic, expirations, latency (N+1)*4, count at expire edge
    vecs[0] = '{n: 3, per: 1'b0, nexp: 1, lat: 16, fcount: 0};
    vecs[1] = '{n: 0, per: 1'b0, nexp: 1, lat: 4,  fcount: 0};
    vecs[2] = '{n: 2, per: 1'b1, nexp: 3, lat: 12, fcount: 2};
    vecs[3] = '{n: 5, per: 1'b0, nexp: 1, lat: 24, fcount: 0};
    vecs[4] = '{n: 7, per: 1'b1, nexp: 2, lat: 32, fcount: 7};

    #12;
    check_reset_state("in_reset");
    #3 reset_n = 1'b1;
    step();
    check_reset_state("post_reset");

    foreach (vecs[i]) begin
      run_load(vecs[i].n, vecs[i].per, vecs[i].nexp, vecs[i].lat, vecs[i].fcount);
    end

    // Cancel on the very edge of the expire tick: periodic N=1 ticks at T+4, T+8.
    load_valid = 1'b1; load_value = 8'd1; mode = 1'b1;
    step();
    load_valid = 1'b0;
    repeat (7) step();
    cancel = 1'b1;
    step();
    check("cx_expire", 32'(expire), 0);
    check("cx_busy", 32'(busy), 0);
    check("cx_ecnt", 32'(expire_cnt), 32'(exp_ecnt));
    check("cx_count", 32'(count), 0);
    step();
    cancel = 1'b0;
    check("idle_cancel_busy", 32'(busy), 0);
    check("idle_cancel_ready", 32'(load_ready), 1);
    check("idle_cancel_expire", 32'(expire), 0);
    check("idle_cancel_ecnt", 32'(expire_cnt), 32'(exp_ecnt));

    // Asynchronous reset mid-run at count=5, prescaler=2.
    load_valid = 1'b1; load_value = 8'd7; mode = 1'b0;
    step();
    load_valid = 1'b0;
    repeat (10) step();
    check("pre_reset_count", 32'(count), 5);
    check("pre_reset_busy", 32'(busy), 1);
    #3 reset_n = 1'b0;
    #1;
    check_reset_state("async_reset");
    #2 reset_n = 1'b1;
    exp_ecnt = 0;
    step();
    run_load(1, 1'b0, 1, 8, 0);

    // Saturation with load_valid held throughout the run.
    load_valid = 1'b1; load_value = 8'd0; mode = 1'b1;
    step();
    load_value = 8'd9;
    for (int i = 1; i <= 1200; i++) begin
      step();
      if (i % PS == 0) bump_ecnt();
      check("sat_ready", 32'(load_ready), 0);
    end
    check("sat_ecnt", 32'(expire_cnt), 255);
    check("sat_count", 32'(count), 0);
    check("sat_expire", 32'(expire), 1);
    cancel = 1'b1; load_valid = 1'b0;
    step();
    cancel = 1'b0;
    check("sat_cancel_busy", 32'(busy), 0);
    check("sat_cancel_ecnt", 32'(expire_cnt), 255);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
